atb_funnel: RTL and testbench

- N-input to 1-output ATB funnel: merges trace streams from several ATB sources onto one ATB master port toward the trace sink.
- Round-robin arbitration with a per-grant hold count, and a single-entry registered output stage.
- Flush is broadcast from the downstream master to every source, then acknowledged back once all sources and the output stage have drained.
- Reserved-ID beats are flagged on a sticky error output and still forwarded.

---
 rtl/atb_pkg.sv | 24 ++
 rtl/atb_funnel_if.sv | 46 ++++
 rtl/atb_rr_arbiter.sv | 29 ++
 rtl/atb_funnel.sv | 158 +++++++++++++++
 tb/tb_atb_funnel.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atb_pkg.sv
// Shared ATB widths, beat payload, funnel state encoding and the reserved-ID test.
package atb_pkg;

  localparam int unsigned ATB_DATA_W  = 32;
  localparam int unsigned ATB_ID_W    = 7;
  localparam int unsigned ATB_BYTES_W = 3;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_e;

  typedef struct packed {
    logic [ATB_DATA_W-1:0]  data;
    logic [ATB_BYTES_W-1:0] bytes;
    logic [ATB_ID_W-1:0]    id;
  } atb_beat_t;

  // 0x00, 0x70-0x7C and 0x7E-0x7F are not usable as trace source IDs
  function automatic logic is_reserved_id(input logic [ATB_ID_W-1:0] id);
    return (id == 7'h00) || ((id >= 7'h70) && (id <= 7'h7C)) || (id >= 7'h7E);
  endfunction

endpackage

// File: rtl/atb_funnel_if.sv
// Bundle of all funnel-facing ATB signals: N slave ports, one master port and the ID error flags.
interface atb_funnel_if #(
  parameter int unsigned NUM_IN = 2
);
  import atb_pkg::*;

  localparam int unsigned PORT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]             s_atvalid;
  logic [NUM_IN-1:0]             s_atready;
  logic [NUM_IN*ATB_DATA_W-1:0]  s_atdata;
  logic [NUM_IN*ATB_BYTES_W-1:0] s_atbytes;
  logic [NUM_IN*ATB_ID_W-1:0]    s_atid;
  logic [NUM_IN-1:0]             s_afvalid;
  logic [NUM_IN-1:0]             s_afready;
  logic [NUM_IN-1:0]             s_syncreq;
  logic                          m_atvalid;
  logic                          m_atready;
  logic [ATB_DATA_W-1:0]         m_atdata;
  logic [ATB_BYTES_W-1:0]        m_atbytes;
  logic [ATB_ID_W-1:0]           m_atid;
  logic                          m_afvalid;
  logic                          m_afready;
  logic                          m_syncreq;
  logic                          id_err;
  logic [PORT_W-1:0]             id_err_port;

  // master: the funnel itself, which masters the downstream ATB port
  modport master (
    input  s_atvalid, s_atdata, s_atbytes, s_atid, s_afready,
           m_atready, m_afvalid, m_syncreq,
    output s_atready, s_afvalid, s_syncreq,
           m_atvalid, m_atdata, m_atbytes, m_atid, m_afready,
           id_err, id_err_port
  );

  // slave: the surrounding sources and sink
  modport slave (
    output s_atvalid, s_atdata, s_atbytes, s_atid, s_afready,
           m_atready, m_afvalid, m_syncreq,
    input  s_atready, s_afvalid, s_syncreq,
           m_atvalid, m_atdata, m_atbytes, m_atid, m_afready,
           id_err, id_err_port
  );

endinterface

// File: rtl/atb_rr_arbiter.sv
// Combinational round-robin pick: first requesting port at or after i_ptr, wrapping modulo NUM_IN.
module atb_rr_arbiter #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned PORT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [PORT_W-1:0] i_ptr,
  output logic [PORT_W-1:0] o_grant,
  output logic              o_any_req
);

  logic        w_found;
  int unsigned w_idx;

  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    o_grant = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      w_idx = (32'(i_ptr) + k) % NUM_IN;
      if (!w_found && i_req[PORT_W'(w_idx)]) begin
        w_found = 1'b1;
        o_grant = PORT_W'(w_idx);
      end
    end
    o_any_req = w_found;
  end

endmodule

// File: rtl/atb_funnel.sv
// N:1 ATB funnel: round-robin grant with a per-grant beat limit, one registered output beat,
// flush broadcast/collect, sync fan-out and sticky reserved-ID flagging.
module atb_funnel
  import atb_pkg::*;
#(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned HOLD   = 4
) (
  input  logic          atclk,
  input  logic          atresetn,
  atb_funnel_if.master  bus
);

  localparam int unsigned PORT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned CNT_W  = $clog2(HOLD + 1);

  state_e            r_state;
  logic [PORT_W-1:0] r_grant;
  logic [PORT_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_m_valid;
  atb_beat_t         r_m_beat;
  logic              r_flush_active;
  logic [NUM_IN-1:0] r_afvalid;
  logic              r_afready;
  logic [NUM_IN-1:0] r_syncreq;
  logic              r_id_err;
  logic [PORT_W-1:0] r_id_err_port;

  logic [PORT_W-1:0] w_arb_grant;
  logic              w_any_req;
  logic [PORT_W-1:0] w_next_ptr;
  logic              w_out_free;
  logic              w_src_valid;
  atb_beat_t         w_beat;
  logic              w_accept;

  atb_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .PORT_W (PORT_W)
  ) u_arb (
    .i_req     (bus.s_atvalid),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_arb_grant),
    .o_any_req (w_any_req)
  );

  assign w_next_ptr = (w_arb_grant == PORT_W'(NUM_IN - 1)) ? '0 : w_arb_grant + PORT_W'(1);
  assign w_out_free = !r_m_valid || bus.m_atready;
  assign w_accept   = (r_state == XFER) && w_src_valid && w_out_free;

  // Select the granted source's valid and payload
  always_comb begin
    w_src_valid = 1'b0;
    w_beat      = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant == PORT_W'(i)) begin
        w_src_valid = bus.s_atvalid[i];
        w_beat      = {bus.s_atdata[i*ATB_DATA_W +: ATB_DATA_W],
                       bus.s_atbytes[i*ATB_BYTES_W +: ATB_BYTES_W],
                       bus.s_atid[i*ATB_ID_W +: ATB_ID_W]};
      end
    end
  end

  // Ready goes only to the granted source, and only while the output stage can take a beat
  always_comb begin
    bus.s_atready = '0;
    if (r_state == XFER) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_grant == PORT_W'(i)) begin
          bus.s_atready[i] = w_out_free;
        end
      end
    end
  end

  always_ff @(posedge atclk) begin
    if (!atresetn) begin
      r_state        <= ARB;
      r_grant        <= '0;
      r_rr_ptr       <= '0;
      r_cnt          <= '0;
      r_m_valid      <= 1'b0;
      r_m_beat       <= '0;
      r_flush_active <= 1'b0;
      r_afvalid      <= '0;
      r_afready      <= 1'b0;
      r_syncreq      <= '0;
      r_id_err       <= 1'b0;
      r_id_err_port  <= '0;
    end else begin
      r_afready <= 1'b0;
      r_syncreq <= {NUM_IN{bus.m_syncreq}};

      case (r_state)
        ARB: begin
          if (w_any_req) begin
            r_grant  <= w_arb_grant;
            r_rr_ptr <= w_next_ptr;
            r_cnt    <= '0;
            r_state  <= XFER;
          end
        end
        XFER: begin
          if (!w_src_valid) begin
            r_state <= ARB;
          end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(HOLD - 1)) begin
              r_state <= ARB;
            end
          end
        end
        default: r_state <= ARB;
      endcase

      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_beat  <= w_beat;
      end else if (bus.m_atready) begin
        r_m_valid <= 1'b0;
      end

      // First reserved-ID beat records its port; later ones only keep the flag set
      if (w_accept && is_reserved_id(w_beat.id)) begin
        r_id_err <= 1'b1;
        if (!r_id_err) begin
          r_id_err_port <= r_grant;
        end
      end

      // Ack only once every source has drained and the output stage is empty
      if (bus.m_afvalid && !r_flush_active && !r_afready) begin
        r_flush_active <= 1'b1;
        r_afvalid      <= '1;
      end else if (r_flush_active) begin
        if ((r_afvalid == '0) && !r_m_valid) begin
          r_afready      <= 1'b1;
          r_flush_active <= 1'b0;
        end else begin
          r_afvalid <= r_afvalid & ~bus.s_afready;
        end
      end
    end
  end

  assign bus.m_atvalid   = r_m_valid;
  assign bus.m_atdata    = r_m_beat.data;
  assign bus.m_atbytes   = r_m_beat.bytes;
  assign bus.m_atid      = r_m_beat.id;
  assign bus.s_afvalid   = r_afvalid;
  assign bus.m_afready   = r_afready;
  assign bus.s_syncreq   = r_syncreq;
  assign bus.id_err      = r_id_err;
  assign bus.id_err_port = r_id_err_port;

endmodule

// File: tb/tb_atb_funnel.sv
// Directed bench for atb_funnel: per-port source queues feed the DUT, a scoreboard of expected
// master beats is checked on every master handshake.
module tb_atb_funnel;
  import atb_pkg::*;

  localparam int unsigned NUM_IN = 2;
  localparam int unsigned HOLD   = 4;

  logic atclk    = 1'b0;
  logic atresetn = 1'b0;

  atb_funnel_if #(.NUM_IN(NUM_IN)) bus ();

  atb_funnel #(
    .NUM_IN (NUM_IN),
    .HOLD   (HOLD)
  ) dut (
    .atclk    (atclk),
    .atresetn (atresetn),
    .bus      (bus)
  );

  always #5 atclk = ~atclk;

  int tests = 0;
  int fails = 0;

  atb_beat_t q0[$];
  atb_beat_t q1[$];
  atb_beat_t exp_q[$];
  logic [1:0] hs;
  logic [18:0] hist;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic atb_beat_t mk(input logic [31:0] d, input logic [2:0] b, input logic [6:0] id);
    atb_beat_t x;
    x.data  = d;
    x.bytes = b;
    x.id    = id;
    return x;
  endfunction

  task automatic push_src(input int port, input atb_beat_t b);
    if (port == 0) q0.push_back(b);
    else           q1.push_back(b);
  endtask

  // Present the head of each source queue on its slave port
  task automatic drive_src();
    atb_beat_t b0;
    atb_beat_t b1;
    b0 = '0;
    b1 = '0;
    if (q0.size() > 0) b0 = q0[0];
    if (q1.size() > 0) b1 = q1[0];
    bus.s_atvalid = {q1.size() > 0, q0.size() > 0};
    bus.s_atdata  = {b1.data, b0.data};
    bus.s_atbytes = {b1.bytes, b0.bytes};
    bus.s_atid    = {b1.id, b0.id};
  endtask

  // One clock: sample handshakes before the edge, advance sources after it, return at negedge
  task automatic step();
    atb_beat_t got;
    atb_beat_t want;
    #1;
    hs = bus.s_atvalid & bus.s_atready;
    if (bus.m_atvalid && bus.m_atready) begin
      got = {bus.m_atdata, bus.m_atbytes, bus.m_atid};
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", 64'(exp_q.size()), 64'(1));
      end else begin
        want = exp_q.pop_front();
        check("sb_beat", 64'(got), 64'(want));
      end
    end
    @(posedge atclk);
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    drive_src();
    @(negedge atclk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.m_atvalid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(bus.m_atvalid), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    atb_beat_t b30;
    bus.m_atready = 1'b1;
    bus.m_afvalid = 1'b0;
    bus.m_syncreq = 1'b0;
    bus.s_afready = '0;
    drive_src();
    @(negedge atclk);
    step();
    step();

    // Reset state
    check("rst_m_atvalid",   64'(bus.m_atvalid),   64'(0));
    check("rst_s_atready",   64'(bus.s_atready),   64'(0));
    check("rst_s_afvalid",   64'(bus.s_afvalid),   64'(0));
    check("rst_m_afready",   64'(bus.m_afready),   64'(0));
    check("rst_s_syncreq",   64'(bus.s_syncreq),   64'(0));
    check("rst_id_err",      64'(bus.id_err),      64'(0));
    check("rst_id_err_port", 64'(bus.id_err_port), 64'(0));
    check("rst_m_atdata",    64'(bus.m_atdata),    64'(0));
    atresetn = 1'b1;

    // Single source, two-cycle latency
    push_src(0, mk(32'hA5A5_A5A5, 3'd3, 7'h10));
    exp_q.push_back(mk(32'hA5A5_A5A5, 3'd3, 7'h10));
    drive_src();
    check("t1_lat0_valid", 64'(bus.m_atvalid), 64'(0));
    step();
    check("t1_lat1_valid", 64'(bus.m_atvalid), 64'(0));
    check("t1_lat1_ready", 64'(bus.s_atready), 64'(2'b01));
    step();
    check("t1_lat2_valid", 64'(bus.m_atvalid), 64'(1));
    check("t1_data",  64'(bus.m_atdata),  64'(32'hA5A5_A5A5));
    check("t1_bytes", 64'(bus.m_atbytes), 64'(3));
    check("t1_id",    64'(bus.m_atid),    64'(7'h10));
    drain("t1", 5);
    check("t1_id_err", 64'(bus.id_err), 64'(0));
    repeat (3) step();

    // Contention: reset first so rr_ptr restarts at port 0
    atresetn = 1'b0;
    step();
    atresetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_src(0, mk(32'h2000_0000 + 32'(i), 3'(i), 7'h20));
      push_src(1, mk(32'h2100_0000 + 32'(i), 3'(i), 7'h21));
    end
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(mk(((g % 2) == 0 ? 32'h2000_0000 : 32'h2100_0000) + 32'((g / 2) * 4 + i),
                           3'((g / 2) * 4 + i), (g % 2) == 0 ? 7'h20 : 7'h21));
      end
    end
    drive_src();
    wait_valid("t2_first_valid", 6);
    hist = '0;
    for (int k = 0; k < 19; k++) begin
      hist = {hist[17:0], bus.m_atvalid};
      step();
    end
    check("t2_valid_pattern", 64'(hist), 64'(19'b1111_0_1111_0_1111_0_1111));
    drain("t2", 20);
    repeat (3) step();

    // Backpressure: held beat stays stable, no source ready
    for (int i = 0; i < 3; i++) begin
      push_src(0, mk(32'hB000_0000 + 32'(i), 3'(i + 1), 7'(8'h30 + i)));
      exp_q.push_back(mk(32'hB000_0000 + 32'(i), 3'(i + 1), 7'(8'h30 + i)));
    end
    b30 = mk(32'hB000_0000, 3'd1, 7'h30);
    drive_src();
    wait_valid("t3_first_valid", 6);
    bus.m_atready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_hold_valid", 64'(bus.m_atvalid), 64'(1));
      check("t3_hold_beat",  64'({bus.m_atdata, bus.m_atbytes, bus.m_atid}), 64'(b30));
      check("t3_s_atready",  64'(bus.s_atready), 64'(0));
    end
    bus.m_atready = 1'b1;
    drain("t3", 10);
    repeat (3) step();

    // Flush with staggered source completions
    push_src(0, mk(32'hC000_0000, 3'd2, 7'h40));
    push_src(0, mk(32'hC000_0001, 3'd2, 7'h40));
    exp_q.push_back(mk(32'hC000_0000, 3'd2, 7'h40));
    exp_q.push_back(mk(32'hC000_0001, 3'd2, 7'h40));
    drive_src();
    bus.m_afvalid = 1'b1;
    step();
    check("t4_afv_start", 64'(bus.s_afvalid), 64'(2'b11));
    check("t4_no_ack1",   64'(bus.m_afready), 64'(0));
    step();
    step();
    check("t4_no_ack3",   64'(bus.m_afready), 64'(0));
    bus.s_afready = 2'b10;
    step();
    bus.s_afready = 2'b00;
    check("t4_afv_port1", 64'(bus.s_afvalid), 64'(2'b01));
    step();
    step();
    check("t4_out_empty", 64'(bus.m_atvalid), 64'(0));
    check("t4_beats_out", 64'(exp_q.size()),  64'(0));
    check("t4_no_ack6",   64'(bus.m_afready), 64'(0));
    bus.s_afready = 2'b01;
    step();
    bus.s_afready = 2'b00;
    check("t4_afv_done",  64'(bus.s_afvalid), 64'(0));
    check("t4_no_early",  64'(bus.m_afready), 64'(0));
    step();
    check("t4_ack",       64'(bus.m_afready), 64'(1));
    bus.m_afvalid = 1'b0;
    step();
    check("t4_ack_1cyc",  64'(bus.m_afready), 64'(0));
    repeat (2) step();

    // Flush where all sources finish together but the output beat is stalled
    bus.m_atready = 1'b0;
    push_src(1, mk(32'hC100_0000, 3'd4, 7'h41));
    exp_q.push_back(mk(32'hC100_0000, 3'd4, 7'h41));
    drive_src();
    wait_valid("t4b_valid", 6);
    bus.m_afvalid = 1'b1;
    step();
    bus.m_afvalid = 1'b0;
    check("t4b_afv_start", 64'(bus.s_afvalid), 64'(2'b11));
    bus.s_afready = 2'b11;
    step();
    bus.s_afready = 2'b00;
    check("t4b_afv_clear", 64'(bus.s_afvalid), 64'(0));
    for (int k = 0; k < 3; k++) begin
      check("t4b_wait_out", 64'(bus.m_afready), 64'(0));
      step();
    end
    bus.m_atready = 1'b1;
    step();
    check("t4b_no_ack_yet", 64'(bus.m_afready), 64'(0));
    step();
    check("t4b_ack",        64'(bus.m_afready), 64'(1));
    step();
    check("t4b_ack_1cyc",   64'(bus.m_afready), 64'(0));
    check("t4b_drained",    64'(exp_q.size()),  64'(0));
    repeat (2) step();

    // Reserved IDs: 0x7D is legal, 0x7E then 0x00 are flagged, port of the first kept
    push_src(0, mk(32'hD000_0000, 3'd0, 7'h7D));
    exp_q.push_back(mk(32'hD000_0000, 3'd0, 7'h7D));
    drive_src();
    drain("t5a", 8);
    step();
    check("t5_7d_legal", 64'(bus.id_err), 64'(0));
    push_src(1, mk(32'hD100_0000, 3'd1, 7'h7E));
    exp_q.push_back(mk(32'hD100_0000, 3'd1, 7'h7E));
    drive_src();
    drain("t5b", 8);
    step();
    check("t5_7e_err",  64'(bus.id_err),      64'(1));
    check("t5_7e_port", 64'(bus.id_err_port), 64'(1));
    push_src(0, mk(32'hD200_0000, 3'd2, 7'h00));
    exp_q.push_back(mk(32'hD200_0000, 3'd2, 7'h00));
    drive_src();
    drain("t5c", 8);
    repeat (2) step();
    check("t5_00_err",         64'(bus.id_err),      64'(1));
    check("t5_port_sticky",    64'(bus.id_err_port), 64'(1));

    // Sync request fan-out with one-cycle delay
    bus.m_syncreq = 1'b1;
    check("t6_sync_delay", 64'(bus.s_syncreq), 64'(0));
    step();
    check("t6_sync_on",    64'(bus.s_syncreq), 64'(2'b11));
    bus.m_syncreq = 1'b0;
    step();
    check("t6_sync_off",   64'(bus.s_syncreq), 64'(0));

    // Reset mid-transfer discards the in-flight beat
    for (int i = 0; i < 3; i++) begin
      push_src(0, mk(32'hE000_0000 + 32'(i), 3'd5, 7'h50));
    end
    drive_src();
    wait_valid("t7_valid", 6);
    bus.m_atready = 1'b0;
    atresetn = 1'b0;
    q0.delete();
    drive_src();
    step();
    atresetn = 1'b1;
    bus.m_atready = 1'b1;
    check("t7_m_atvalid",   64'(bus.m_atvalid),   64'(0));
    check("t7_s_atready",   64'(bus.s_atready),   64'(0));
    check("t7_m_atdata",    64'(bus.m_atdata),    64'(0));
    check("t7_m_atid",      64'(bus.m_atid),      64'(0));
    check("t7_id_err",      64'(bus.id_err),      64'(0));
    check("t7_id_err_port", 64'(bus.id_err_port), 64'(0));
    push_src(1, mk(32'hE100_0000, 3'd6, 7'h51));
    exp_q.push_back(mk(32'hE100_0000, 3'd6, 7'h51));
    drive_src();
    step();
    check("t7_grant_port1", 64'(bus.s_atready), 64'(2'b10));
    step();
    check("t7_out_valid",   64'(bus.m_atvalid), 64'(1));
    drain("t7", 6);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
